// File: rtl/cache_ctrl_if.sv
// Bundle of the CPU load port, cache_mem port and RAM beat port seen by cache_ctrl.
// master = the controller, slave = the CPU / cache_mem / RAM side.
interface cache_ctrl_if #(
  parameter int WORDS = 16,
  parameter int SIZE  = 32
);
  localparam int BLOCK_SIZE = WORDS * SIZE;

  logic                  cpu_req;
  logic [31:0]           cpu_addr;
  logic                  cpu_busy;
  logic                  cpu_ready;
  logic [SIZE-1:0]       cpu_data;

  logic [31:0]           cache_addr;
  logic                  cache_read;
  logic [BLOCK_SIZE-1:0] cache_data;
  logic                  cache_hit;
  logic [SIZE-1:0]       cache_dout;

  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_valid;
  logic [SIZE-1:0]       mem_data;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, cache_dout, mem_valid, mem_data,
    output cpu_busy, cpu_ready, cpu_data, cache_addr, cache_read, cache_data,
           mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, cache_dout, mem_valid, mem_data,
    input  cpu_busy, cpu_ready, cpu_data, cache_addr, cache_read, cache_data,
           mem_req, mem_addr
  );
endinterface

// File: rtl/cache_ctrl.sv
// Read-miss sequencer for a direct-mapped cache_mem: probe, 16-beat block fetch, fill, respond.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
  parameter int WORDS      = 16,
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = WORDS * SIZE
) (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.master bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int BEAT_W = $clog2(WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROBE   = 3'd1,
    S_CHECK   = 3'd2,
    S_FETCH   = 3'd3,
    S_FILL_WR = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [31:0]           addr_r;
  logic [BEAT_W-1:0]     beat_r;
  logic [SIZE-1:0]       cpu_data_r;
  logic                  cpu_ready_r;
  logic [BLOCK_SIZE-1:0] cache_data_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.cpu_req) begin
          state_nxt_s = S_PROBE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PROBE: state_nxt_s = S_CHECK;
      S_CHECK: begin
        if (bus.cache_hit) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.mem_valid && (beat_r == LAST_BEAT)) begin
          state_nxt_s = S_FILL_WR;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_FILL_WR: state_nxt_s = S_RESP;
      S_RESP:    state_nxt_s = S_IDLE;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Request latch, beat assembly and CPU response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r       <= 32'd0;
      beat_r       <= '0;
      cpu_data_r   <= '0;
      cpu_ready_r  <= 1'b0;
      cache_data_r <= '0;
    end else begin
      cpu_ready_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.cpu_req) begin
            addr_r <= bus.cpu_addr;
          end
        end
        S_CHECK: begin
          if (bus.cache_hit) begin
            cpu_data_r  <= bus.cache_dout;
            cpu_ready_r <= 1'b1;
          end else begin
            beat_r <= '0;
          end
        end
        S_FETCH: begin
          if (bus.mem_valid) begin
            cache_data_r[beat_r*SIZE +: SIZE] <= bus.mem_data;
            beat_r <= beat_r + 1'b1;
          end
        end
        S_RESP: begin
          cpu_data_r  <= bus.cache_dout;
          cpu_ready_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Cache only ever sees a write strobe during the single fill cycle, including across reset
  assign bus.cache_read = (state_r != S_FILL_WR);
  assign bus.cache_addr = addr_r;
  assign bus.cache_data = cache_data_r;
  assign bus.mem_req    = (state_r == S_FETCH);
  assign bus.mem_addr   = {addr_r[31:BEAT_W], {BEAT_W{1'b0}}};
  assign bus.cpu_busy   = (state_r != S_IDLE);
  assign bus.cpu_ready  = cpu_ready_r;
  assign bus.cpu_data   = cpu_data_r;

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating hit/miss counters, one event per CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else if (state_r == S_CHECK) begin
      if (bus.cache_hit) begin
        if (hit_cnt_r != 32'hFFFF_FFFF) begin
          hit_cnt_r <= hit_cnt_r + 32'd1;
        end
      end else begin
        if (miss_cnt_r != 32'hFFFF_FFFF) begin
          miss_cnt_r <= miss_cnt_r + 32'd1;
        end
      end
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural cache_mem and burst RAM models.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // cache_mem model: registered lookup when read=1, block write + dataOut when read=0
  logic [255:0] valid_m = '0;
  logic [19:0]  tag_m [256];
  logic [511:0] blk_m [256];

  always @(posedge clk) begin
    if (bus.cache_read) begin
      bus.cache_hit  <= valid_m[bus.cache_addr[11:4]] &&
                        (tag_m[bus.cache_addr[11:4]] == bus.cache_addr[31:12]);
      bus.cache_dout <= blk_m[bus.cache_addr[11:4]][bus.cache_addr[3:0]*32 +: 32];
    end else begin
      valid_m[bus.cache_addr[11:4]] <= 1'b1;
      tag_m[bus.cache_addr[11:4]]   <= bus.cache_addr[31:12];
      blk_m[bus.cache_addr[11:4]]   <= bus.cache_data;
      bus.cache_hit  <= 1'b1;
      bus.cache_dout <= bus.cache_data[bus.cache_addr[3:0]*32 +: 32];
    end
  end

  // RAM model: word k = mem_base + k, mem_gap idle cycles after each beat
  logic [31:0] mem_base = 32'd0;
  int          mem_gap  = 0;
  int          mem_beat = 0;
  int          gap_left = 0;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_valid) begin
        mem_beat++;
        gap_left = mem_gap;
      end
      if (bus.mem_req && (mem_beat < 16)) begin
        if (gap_left > 0) begin
          bus.mem_valid = 1'b0;
          gap_left--;
        end else begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = mem_base + 32'(mem_beat);
        end
      end else begin
        bus.mem_valid = 1'b0;
        if (!bus.mem_req) begin
          mem_beat = 0;
          gap_left = 0;
        end
      end
    end
  end

  int          lat_g;
  int          fetch_g;
  int          mreq_cyc_g;
  int          rdlow_g;
  logic [31:0] data_g;
  logic [31:0] maddr_g;
  logic [31:0] caddr_g;
  int          exp_hit  = 0;
  int          exp_miss = 0;

  // One CPU read held until cpu_ready; optionally swaps the address for a cycle mid-fetch
  task automatic run_req(input logic [31:0] addr, input logic [31:0] base,
                         input int gap, input bit intrude);
    bit prev_mreq = 1'b0;
    mem_base   = base;
    mem_gap    = gap;
    lat_g      = 0;
    fetch_g    = 0;
    mreq_cyc_g = 0;
    rdlow_g    = 0;
    data_g     = 32'd0;
    maddr_g    = 32'd0;
    caddr_g    = 32'd0;
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        mreq_cyc_g++;
        if (!prev_mreq) begin
          fetch_g++;
          maddr_g = bus.mem_addr;
        end
      end
      prev_mreq = bus.mem_req;
      if (!bus.cache_read) rdlow_g++;
      if (intrude && (c == 6)) bus.cpu_addr = 32'h0000_7770;
      if (intrude && (c == 7)) begin
        caddr_g      = bus.cache_addr;
        bus.cpu_addr = addr;
      end
      if (bus.cpu_ready) begin
        lat_g  = c;
        data_g = bus.cpu_data;
        break;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    logic [31:0] eh;
    logic [31:0] em;
`ifdef CACHE_CTRL_STATS_EN
    eh = 32'(exp_hit);
    em = 32'(exp_miss);
`else
    eh = 32'd0;
    em = 32'd0;
`endif
    check_val({tag, "_hits"}, hit_count, eh);
    check_val({tag, "_misses"}, miss_count, em);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cache_read", 32'(bus.cache_read), 32'd1);
    check_val("rst_mem_req",    32'(bus.mem_req),    32'd0);
    check_val("rst_busy",       32'(bus.cpu_busy),   32'd0);
    check_val("rst_ready",      32'(bus.cpu_ready),  32'd0);
    check_val("rst_cpu_data",   bus.cpu_data,        32'd0);
    check_val("rst_cache_addr", bus.cache_addr,      32'd0);
    check_stats("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss
    run_req(32'h0000_1234, 32'hA000_0000, 0, 1'b0);
    exp_miss++;
    check_val("cold_lat",     32'(lat_g),      32'd21);
    check_val("cold_data",    data_g,          32'hA000_0004);
    check_val("cold_maddr",   maddr_g,         32'h0000_1230);
    check_val("cold_fetches", 32'(fetch_g),    32'd1);
    check_val("cold_mreq",    32'(mreq_cyc_g), 32'd16);
    check_val("cold_rdlow",   32'(rdlow_g),    32'd1);
    check_val("cold_word15",  bus.cache_data[511:480], 32'hA000_000F);

    // Hit in the freshly filled block, issued back-to-back
    run_req(32'h0000_123F, 32'h0000_0000, 0, 1'b0);
    exp_hit++;
    check_val("hit_lat",     32'(lat_g),   32'd3);
    check_val("hit_data",    data_g,       32'hA000_000F);
    check_val("hit_fetches", 32'(fetch_g), 32'd0);
    check_val("hit_rdlow",   32'(rdlow_g), 32'd0);
    check_stats("hit");

    // Conflict miss on index 0x23, then the evicted tag misses again
    run_req(32'h0001_1234, 32'hB000_0000, 0, 1'b0);
    exp_miss++;
    check_val("conf1_lat",   32'(lat_g), 32'd21);
    check_val("conf1_data",  data_g,     32'hB000_0004);
    check_val("conf1_maddr", maddr_g,    32'h0001_1230);
    run_req(32'h0000_1234, 32'hC000_0000, 0, 1'b0);
    exp_miss++;
    check_val("conf2_lat",   32'(lat_g), 32'd21);
    check_val("conf2_data",  data_g,     32'hC000_0004);
    check_val("conf2_maddr", maddr_g,    32'h0000_1230);

    // One idle cycle between every beat
    run_req(32'h0000_5678, 32'hD000_0000, 1, 1'b0);
    exp_miss++;
    check_val("gap_lat",     32'(lat_g),      32'd36);
    check_val("gap_data",    data_g,          32'hD000_0008);
    check_val("gap_fetches", 32'(fetch_g),    32'd1);
    check_val("gap_mreq",    32'(mreq_cyc_g), 32'd31);
    check_stats("gap");

    // Reset after the eighth beat (word 7) has been taken
    mem_base     = 32'hE000_0000;
    mem_gap      = 0;
    bus.cpu_addr = 32'h0000_9AB4;
    bus.cpu_req  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #2;
      if (mem_beat >= 8) break;
    end
    check_val("rstmid_beats", 32'(mem_beat), 32'd8);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check_val("rstmid_mem_req",    32'(bus.mem_req),    32'd0);
    check_val("rstmid_cache_read", 32'(bus.cache_read), 32'd1);
    check_val("rstmid_busy",       32'(bus.cpu_busy),   32'd0);
    check_val("rstmid_fill_buf",   bus.cache_data[31:0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_hit  = 0;
    exp_miss = 0;
    check_stats("rstmid");
    @(posedge clk);
    #1;
    run_req(32'h0000_9AB4, 32'hF000_0000, 0, 1'b0);
    exp_miss++;
    check_val("after_rst_fetches", 32'(fetch_g), 32'd1);
    check_val("after_rst_lat",     32'(lat_g),   32'd21);
    check_val("after_rst_data",    data_g,       32'hF000_0004);

    // Different address presented while busy must not disturb the fetch
    run_req(32'h0000_2340, 32'h1100_0000, 0, 1'b1);
    exp_miss++;
    check_val("busy_lat",   32'(lat_g), 32'd21);
    check_val("busy_data",  data_g,     32'h1100_0000);
    check_val("busy_maddr", maddr_g,    32'h0000_2340);
    check_val("busy_caddr", caddr_g,    32'h0000_2340);
    run_req(32'h0000_2345, 32'h0000_0000, 0, 1'b0);
    exp_hit++;
    check_val("busy_hit_lat",  32'(lat_g), 32'd3);
    check_val("busy_hit_data", data_g,     32'h1100_0005);
    check_stats("end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
